// File: rtl/fetch_seq.sv
// fetch_seq: program counter / fetch sequencer running NUM_PROGS windowed programs back to back.
// Define FETCH_RAS_EN to compile in the return-address stack used by Call/Ret.
module fetch_seq #(
   parameter int                          PC_W      = 16,
   parameter int                          NUM_PROGS = 3,
   parameter logic [NUM_PROGS*PC_W-1:0]   PROG_BASE = {16'd301, 16'd124, 16'd0},
   parameter logic [NUM_PROGS*PC_W-1:0]   PROG_LAST = {16'd511, 16'd300, 16'd123},
   parameter int                          RAS_DEPTH = 4,
   localparam int                         IDX_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
   input  logic              CLK,
   input  logic              Init,
   input  logic              Start,
   input  logic              Stall,
   input  logic              Branch_abs,
   input  logic              Branch_rel_z,
   input  logic              Branch_rel_nz,
   input  logic              ALU_zero,
   input  logic              Call,
   input  logic              Ret,
   input  logic [PC_W-1:0]   Target,
   output logic [PC_W-1:0]   PC,
   output logic [IDX_W-1:0]  Prog_Idx,
   output logic              Busy,
   output logic              DONE,
   output logic              RAS_Err
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              done_q, done_d;
   logic [PC_W-1:0]   base_pc, last_pc, seq_pc;

`ifdef FETCH_RAS_EN
   localparam int SP_W   = $clog2(RAS_DEPTH + 1);
   localparam int RAS_AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   logic [PC_W-1:0]   ras_q [RAS_DEPTH];
   logic [SP_W-1:0]   sp_q, sp_d;
   logic              err_q, err_d;
   logic              push_en;
   logic [PC_W-1:0]   push_pc;
`else
   logic              unused_ras;
   assign unused_ras = ^{Call, Ret};
`endif

   always_comb begin
      base_pc = PROG_BASE[PC_W-1:0];
      last_pc = PROG_LAST[PC_W-1:0];
      for (int i = 0; i < NUM_PROGS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            base_pc = PROG_BASE[i*PC_W +: PC_W];
            last_pc = PROG_LAST[i*PC_W +: PC_W];
         end
      end
   end

   // Non-stack successor: absolute branch, taken relative branch, else fall through.
   always_comb begin
      if (Branch_abs)
         seq_pc = Target;
      else if ((Branch_rel_z && ALU_zero) || (Branch_rel_nz && !ALU_zero))
         seq_pc = pc_q + Target;
      else
         seq_pc = pc_q + PC_W'(1);
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      idx_d   = idx_q;
      done_d  = done_q;
`ifdef FETCH_RAS_EN
      sp_d    = sp_q;
      err_d   = err_q;
      push_en = 1'b0;
      push_pc = pc_q + PC_W'(1);
`endif
      case (state_q)
         S_RUN: begin
            if (!Stall) begin
               if (pc_q == last_pc) begin
                  state_d = S_HALT;
                  done_d  = 1'b1;
                  idx_d   = (idx_q == IDX_W'(NUM_PROGS - 1)) ? '0 : idx_q + IDX_W'(1);
               end else begin
                  pc_d = seq_pc;
`ifdef FETCH_RAS_EN
                  // Ret outranks Call; a failed pop still advances the PC.
                  if (Ret) begin
                     if (sp_q == '0) begin
                        pc_d  = pc_q + PC_W'(1);
                        err_d = 1'b1;
                     end else begin
                        pc_d = ras_q[RAS_AW'(sp_q - SP_W'(1))];
                        sp_d = sp_q - SP_W'(1);
                     end
                  end else if (Call) begin
                     pc_d = Target;
                     if (sp_q == SP_W'(RAS_DEPTH)) begin
                        err_d = 1'b1;
                     end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SP_W'(1);
                     end
                  end
`endif
               end
            end
         end
         default: begin
            if (Start) begin
               state_d = S_RUN;
               pc_d    = base_pc;
               done_d  = 1'b0;
`ifdef FETCH_RAS_EN
               sp_d    = '0;
               err_d   = 1'b0;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge CLK or posedge Init) begin
      if (Init) begin
         state_q <= S_IDLE;
         pc_q    <= PROG_BASE[PC_W-1:0];
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

`ifdef FETCH_RAS_EN
   always_ff @(posedge CLK or posedge Init) begin
      if (Init) begin
         sp_q  <= '0;
         err_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         err_q <= err_d;
      end
   end

   // Stack contents are plain data; the pointer alone decides validity.
   always_ff @(posedge CLK) begin
      if (push_en)
         ras_q[RAS_AW'(sp_q)] <= push_pc;
   end

   assign RAS_Err = err_q;
`else
   assign RAS_Err = 1'b0;
`endif

   assign PC       = pc_q;
   assign Prog_Idx = idx_q;
   assign Busy     = (state_q == S_RUN);
   assign DONE     = done_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: vector table, directed corner sequences, random run vs. model.
module tb_fetch_seq;
   localparam int PC_W      = 16;
   localparam int NUM_PROGS = 3;
   localparam int RAS_DEPTH = 4;
   localparam logic [NUM_PROGS*PC_W-1:0] BASE_V = {16'd301, 16'd124, 16'd0};
   localparam logic [NUM_PROGS*PC_W-1:0] LAST_V = {16'd511, 16'd300, 16'd123};
`ifdef FETCH_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   logic CLK = 1'b0;
   logic Init, Start, Stall, Branch_abs, Branch_rel_z, Branch_rel_nz, ALU_zero, Call, Ret;
   logic [15:0] Target, PC;
   logic [1:0]  Prog_Idx;
   logic        Busy, DONE, RAS_Err;

   int n_tests = 0;
   int n_fail  = 0;

   int BASES[3] = '{0, 124, 301};
   int LASTS[3] = '{123, 300, 511};

   // reference model state
   logic [15:0] m_pc;
   bit          m_run, m_done, m_err;
   int          m_idx;
   logic [15:0] m_stk[$];

   typedef struct {
      logic        start, stall, babs, brz, brnz, z;
      logic [15:0] tgt;
      logic [15:0] pc;
      logic        busy, done;
   } vec_t;
   localparam int NV = 14;
   vec_t vt[NV];

   always #5 CLK = ~CLK;

   fetch_seq #(
      .PC_W(PC_W), .NUM_PROGS(NUM_PROGS), .PROG_BASE(BASE_V), .PROG_LAST(LAST_V), .RAS_DEPTH(RAS_DEPTH)
   ) dut (
      .CLK(CLK), .Init(Init), .Start(Start), .Stall(Stall), .Branch_abs(Branch_abs),
      .Branch_rel_z(Branch_rel_z), .Branch_rel_nz(Branch_rel_nz), .ALU_zero(ALU_zero),
      .Call(Call), .Ret(Ret), .Target(Target), .PC(PC), .Prog_Idx(Prog_Idx),
      .Busy(Busy), .DONE(DONE), .RAS_Err(RAS_Err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_in();
      Start = 0; Stall = 0; Branch_abs = 0; Branch_rel_z = 0; Branch_rel_nz = 0;
      ALU_zero = 0; Call = 0; Ret = 0; Target = '0;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic goto_pc(input logic [15:0] a);
      Branch_abs = 1; Target = a;
      step();
      Branch_abs = 0;
      check("goto_pc", PC, a);
   endtask

   task automatic check_all(input string name, input logic [15:0] pc, input logic busy,
                            input logic done, input logic [1:0] idx, input logic err);
      check({name, "_pc"}, PC, pc);
      check({name, "_busy"}, Busy, busy);
      check({name, "_done"}, DONE, done);
      check({name, "_idx"}, Prog_Idx, idx);
      check({name, "_err"}, RAS_Err, err);
   endtask

   task automatic model_reset();
      m_pc = 16'(BASES[0]); m_run = 0; m_done = 0; m_err = 0; m_idx = 0;
      m_stk.delete();
   endtask

   task automatic model_step();
      if (!m_run) begin
         if (Start) begin
            m_run = 1; m_pc = 16'(BASES[m_idx]); m_done = 0; m_err = 0;
            m_stk.delete();
         end
      end else if (!Stall) begin
         if (m_pc == 16'(LASTS[m_idx])) begin
            m_run = 0; m_done = 1; m_idx = (m_idx + 1) % NUM_PROGS;
         end else if (RAS_ON && Ret) begin
            if (m_stk.size() == 0) begin
               m_pc = m_pc + 16'd1; m_err = 1;
            end else begin
               m_pc = m_stk.pop_back();
            end
         end else if (RAS_ON && Call) begin
            if (m_stk.size() == RAS_DEPTH) m_err = 1;
            else m_stk.push_back(m_pc + 16'd1);
            m_pc = Target;
         end else if (Branch_abs) begin
            m_pc = Target;
         end else if ((Branch_rel_z && ALU_zero) || (Branch_rel_nz && !ALU_zero)) begin
            m_pc = m_pc + Target;
         end else begin
            m_pc = m_pc + 16'd1;
         end
      end
   endtask

   initial begin
      //          start stall babs brz brnz z  tgt       pc       busy done
      vt[0]  = '{0, 0, 0, 1, 0, 1, 16'hFFFC, 16'd6,     1, 0};
      vt[1]  = '{0, 0, 0, 0, 0, 0, 16'd0,    16'd7,     1, 0};
      vt[2]  = '{0, 0, 1, 0, 0, 0, 16'd10,   16'd10,    1, 0};
      vt[3]  = '{0, 0, 0, 1, 0, 0, 16'hFFFC, 16'd11,    1, 0};
      vt[4]  = '{0, 0, 1, 0, 0, 0, 16'd10,   16'd10,    1, 0};
      vt[5]  = '{0, 0, 0, 0, 1, 0, 16'd5,    16'd15,    1, 0};
      vt[6]  = '{0, 0, 0, 0, 1, 1, 16'd5,    16'd16,    1, 0};
      vt[7]  = '{0, 1, 1, 0, 0, 0, 16'd99,   16'd16,    1, 0};
      vt[8]  = '{1, 0, 0, 0, 0, 0, 16'd0,    16'd17,    1, 0};
      vt[9]  = '{0, 0, 1, 1, 0, 1, 16'd100,  16'd100,   1, 0};
      vt[10] = '{0, 0, 0, 1, 0, 1, 16'd2,    16'd102,   1, 0};
      vt[11] = '{0, 0, 0, 0, 1, 1, 16'd2,    16'd103,   1, 0};
      vt[12] = '{0, 0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF,  1, 0};
      vt[13] = '{0, 0, 0, 0, 0, 0, 16'd0,    16'd0,     1, 0};

      clear_in();
      Init = 1;
      #3;
      check_all("reset", 16'd0, 0, 0, 2'd0, 0);
      repeat (2) step();
      Init = 0;
      step(); step();
      check_all("idle_hold", 16'd0, 0, 0, 2'd0, 0);

      Start = 1;
      step();
      Start = 0;
      check_all("start0", 16'd0, 1, 0, 2'd0, 0);
      goto_pc(16'd10);

      for (int i = 0; i < NV; i++) begin
         Start = vt[i].start; Stall = vt[i].stall; Branch_abs = vt[i].babs;
         Branch_rel_z = vt[i].brz; Branch_rel_nz = vt[i].brnz; ALU_zero = vt[i].z;
         Target = vt[i].tgt;
         step();
         check($sformatf("vec%0d_pc", i), PC, vt[i].pc);
         check($sformatf("vec%0d_busy", i), Busy, vt[i].busy);
         check($sformatf("vec%0d_done", i), DONE, vt[i].done);
      end
      clear_in();

      for (int i = 1; i <= 123; i++) begin
         step();
         check($sformatf("walk%0d", i), PC, i);
      end

      Stall = 1;
      for (int k = 0; k < 3; k++) begin
         step();
         check_all($sformatf("stall%0d", k), 16'd123, 1, 0, 2'd0, 0);
      end
      Stall = 0; Branch_abs = 1; Target = 16'd5;
      step();
      clear_in();
      check_all("term0", 16'd123, 0, 1, 2'd1, 0);
      step(); step();
      check_all("halt_hold", 16'd123, 0, 1, 2'd1, 0);

      Start = 1;
      step();
      Start = 0;
      check_all("start1", 16'd124, 1, 0, 2'd1, 0);
      goto_pc(16'd77);
      #2 Init = 1;
      #1;
      check_all("async_init", 16'd0, 0, 0, 2'd0, 0);
      #2 Init = 0;

      Start = 1; step(); Start = 0;
      check_all("wrap_s0", 16'd0, 1, 0, 2'd0, 0);
      goto_pc(16'd123);
      step();
      check_all("wrap_t0", 16'd123, 0, 1, 2'd1, 0);
      Start = 1; step(); Start = 0;
      check_all("wrap_s1", 16'd124, 1, 0, 2'd1, 0);
      goto_pc(16'd300);
      step();
      check_all("wrap_t1", 16'd300, 0, 1, 2'd2, 0);
      Start = 1; step(); Start = 0;
      check_all("wrap_s2", 16'd301, 1, 0, 2'd2, 0);
      goto_pc(16'd511);
      step();
      check_all("wrap_t2", 16'd511, 0, 1, 2'd0, 0);
      Start = 1; step(); Start = 0;
      check_all("wrap_s3", 16'd0, 1, 0, 2'd0, 0);

      goto_pc(16'd20);
`ifdef FETCH_RAS_EN
      Call = 1; Target = 16'd50; step();
      check_all("call", 16'd50, 1, 0, 2'd0, 0);
      Call = 0; Ret = 1; step(); Ret = 0;
      check_all("ret", 16'd21, 1, 0, 2'd0, 0);
      Call = 1; Target = 16'd50;
      for (int k = 0; k < 4; k++) begin
         step();
         check_all($sformatf("nest%0d", k), 16'd50, 1, 0, 2'd0, 0);
      end
      step();
      check_all("overflow", 16'd50, 1, 0, 2'd0, 1);
      Ret = 1; step(); clear_in();
      check_all("ret_wins", 16'd51, 1, 0, 2'd0, 1);
      Init = 1; step(); Init = 0;
      Start = 1; step(); Start = 0;
      check_all("restart", 16'd0, 1, 0, 2'd0, 0);
      Ret = 1; step(); Ret = 0;
      check_all("underflow", 16'd1, 1, 0, 2'd0, 1);
`else
      Call = 1; Target = 16'd50; step();
      check_all("call_ign", 16'd21, 1, 0, 2'd0, 0);
      Call = 0; Ret = 1; step();
      check_all("ret_ign", 16'd22, 1, 0, 2'd0, 0);
      Call = 1; Branch_abs = 1; step(); clear_in();
      check_all("call_abs", 16'd50, 1, 0, 2'd0, 0);
`endif

      clear_in();
      Init = 1; step(); Init = 0;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         Start         = ($urandom_range(0, 7) == 0);
         Stall         = ($urandom_range(0, 4) == 0);
         Branch_abs    = ($urandom_range(0, 9) == 0);
         Branch_rel_z  = ($urandom_range(0, 7) == 0);
         Branch_rel_nz = ($urandom_range(0, 7) == 0);
         ALU_zero      = $urandom_range(0, 1);
         Call          = ($urandom_range(0, 9) == 0);
         Ret           = ($urandom_range(0, 9) == 0);
         if (Branch_abs || Call) begin
            if ($urandom_range(0, 1) == 0) Target = 16'(LASTS[m_idx] - $urandom_range(0, 3));
            else Target = 16'($urandom_range(0, 511));
         end else begin
            Target = 16'($urandom_range(0, 16)) - 16'd8;
         end
         model_step();
         step();
         check($sformatf("rnd%0d_pc", c), PC, m_pc);
         check($sformatf("rnd%0d_busy", c), Busy, m_run);
         check($sformatf("rnd%0d_done", c), DONE, m_done);
         check($sformatf("rnd%0d_idx", c), Prog_Idx, m_idx);
         check($sformatf("rnd%0d_err", c), RAS_Err, m_err);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
